// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the accumulator ALU: opcode encodings and the
//   control FSM state type. Imported by alu_acc.
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam int OPC_WIDTH = 4;

  localparam logic [OPC_WIDTH-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_WIDTH-1:0] OP_LD  = 4'h1;
  localparam logic [OPC_WIDTH-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_WIDTH-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_WIDTH-1:0] OP_AND = 4'h4;
  localparam logic [OPC_WIDTH-1:0] OP_OR  = 4'h5;
  localparam logic [OPC_WIDTH-1:0] OP_XOR = 4'h6;
  localparam logic [OPC_WIDTH-1:0] OP_NOT = 4'h7;
  localparam logic [OPC_WIDTH-1:0] OP_SHL = 4'h8;
  localparam logic [OPC_WIDTH-1:0] OP_SHR = 4'h9;
  localparam logic [OPC_WIDTH-1:0] OP_ADC = 4'hA;
  localparam logic [OPC_WIDTH-1:0] OP_CMP = 4'hB;
  localparam logic [OPC_WIDTH-1:0] OP_MUL = 4'hC;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage : alu_pkg

// File: rtl/mul_seq.sv
// ----------------------------------------------------------------------------
// mul_seq
//   Unsigned shift-add multiplier, one partial product per clock, WIDTH steps.
//   Ports:
//     CLK      rising-edge clock
//     RST      synchronous active-high reset (aborts a multiply in flight)
//     start_i  load operands and begin; ignored while busy_o is high
//     a_i/b_i  multiplicand / multiplier, latched on start
//     busy_o   high for exactly WIDTH cycles after the start edge
//     done_o   high during the final step; the edge that ends this cycle
//              completes the multiply
//     prod_o   running sum after the current step; the full product while
//              done_o is high
//   WIDTH must be at least 2.
// ----------------------------------------------------------------------------
module mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] sum_q;

  logic [2*WIDTH-1:0] addend_s;
  logic [2*WIDTH-1:0] sum_next_s;
  logic               last_s;

  // Partial-product adder for the current multiplier bit.
  always_comb begin
    addend_s   = mplier_q[0] ? mcand_q : '0;
    sum_next_s = sum_q + addend_s;
    last_s     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Operand latch, shift registers and step counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sum_q    <= '0;
    end else if (!busy_q) begin
      if (start_i) begin
        busy_q   <= 1'b1;
        cnt_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, a_i};
        mplier_q <= b_i;
        sum_q    <= '0;
      end
    end else begin
      sum_q    <= sum_next_s;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (last_s) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = last_s;
  assign prod_o = sum_next_s;

endmodule : mul_seq

// File: rtl/alu_acc.sv
// ----------------------------------------------------------------------------
// alu_acc
//   Accumulator ALU fed by the register-file read port. Operand A is the
//   internal accumulator, operand B is IN_B. All ops finish in one cycle
//   except MUL, which runs WIDTH cycles in mul_seq while BUSY stalls the
//   sequencer.
//   Ports:
//     CLK     rising-edge clock
//     RST     synchronous active-high reset, overrides everything
//     EN      op request, accepted on an edge when BUSY=0
//     OPC     opcode (see alu_pkg), sampled with EN
//     IN_B    operand B, sampled with EN
//     ACC     accumulator, returns to the register-file write bus
//     MUL_HI  upper half of the last MUL product
//     C, Z    carry/borrow and zero flags
//     BUSY    multiply in progress; EN is ignored
//     DONE    one-cycle pulse after an op's result is written
// ----------------------------------------------------------------------------
module alu_acc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPC_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [OPC_W-1:0] OPC,
  input  logic [WIDTH-1:0] IN_B,
  output logic [WIDTH-1:0] ACC,
  output logic [WIDTH-1:0] MUL_HI,
  output logic             C,
  output logic             Z,
  output logic             BUSY,
  output logic             DONE
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             done_q, done_d;

  logic             mul_start_s;
  logic             mul_busy_s;
  logic             mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;

  logic             cin_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;

  mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .CLK     (CLK),
    .RST     (RST),
    .start_i (mul_start_s),
    .a_i     (acc_q),
    .b_i     (IN_B),
    .busy_o  (mul_busy_s),
    .done_o  (mul_done_s),
    .prod_o  (mul_prod_s)
  );

  // Shared adder serves ADD and ADC; the subtractor's top bit is the borrow.
  always_comb begin
    cin_s  = (OPC == OP_ADC) ? c_q : 1'b0;
    sum_s  = {1'b0, acc_q} + {1'b0, IN_B} + {{WIDTH{1'b0}}, cin_s};
    diff_s = {1'b0, acc_q} - {1'b0, IN_B};
  end

  // Next-state logic: single-cycle op mux plus IDLE/MUL sequencing.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    hi_d        = hi_q;
    c_d         = c_q;
    z_d         = z_q;
    done_d      = 1'b0;
    mul_start_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (EN) begin
          done_d = 1'b1;
          case (OPC)
            OP_LD: begin
              acc_d = IN_B;
              z_d   = (IN_B == '0);
            end
            OP_ADD, OP_ADC: begin
              acc_d = sum_s[WIDTH-1:0];
              c_d   = sum_s[WIDTH];
              z_d   = (sum_s[WIDTH-1:0] == '0);
            end
            OP_SUB: begin
              acc_d = diff_s[WIDTH-1:0];
              c_d   = diff_s[WIDTH];
              z_d   = (diff_s[WIDTH-1:0] == '0);
            end
            OP_AND: begin
              acc_d = acc_q & IN_B;
              z_d   = ((acc_q & IN_B) == '0);
            end
            OP_OR: begin
              acc_d = acc_q | IN_B;
              z_d   = ((acc_q | IN_B) == '0);
            end
            OP_XOR: begin
              acc_d = acc_q ^ IN_B;
              z_d   = ((acc_q ^ IN_B) == '0);
            end
            OP_NOT: begin
              acc_d = ~acc_q;
              z_d   = (acc_q == {WIDTH{1'b1}});
            end
            OP_SHL: begin
              acc_d = acc_q << 1;
              c_d   = acc_q[WIDTH-1];
              z_d   = (acc_q[WIDTH-2:0] == '0);
            end
            OP_SHR: begin
              acc_d = acc_q >> 1;
              c_d   = acc_q[0];
              z_d   = (acc_q[WIDTH-1:1] == '0);
            end
            OP_CMP: begin
              c_d = diff_s[WIDTH];
              z_d = (acc_q == IN_B);
            end
            OP_MUL: begin
              // Result and DONE come from the S_MUL branch on the last step.
              mul_start_s = 1'b1;
              state_d     = S_MUL;
              done_d      = 1'b0;
            end
            default: begin
              // NOP and unused opcodes: only DONE pulses.
            end
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      S_MUL: begin
        // EN is ignored here; ACC keeps its pre-MUL value until the last step.
        if (mul_done_s) begin
          acc_d   = mul_prod_s[WIDTH-1:0];
          hi_d    = mul_prod_s[2*WIDTH-1:WIDTH];
          c_d     = (mul_prod_s[2*WIDTH-1:WIDTH] != '0);
          z_d     = (mul_prod_s == '0);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_MUL;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      hi_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      c_q     <= c_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

  assign ACC    = acc_q;
  assign MUL_HI = hi_q;
  assign C      = c_q;
  assign Z      = z_q;
  assign BUSY   = (state_q == S_MUL) && mul_busy_s;
  assign DONE   = done_q;

endmodule : alu_acc
